// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage (package if_pkg).
package if_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_STEP   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: control inputs, instruction-memory link and IF/ID outputs.
// Performance counters are present only when FETCH_PERF_CNT_EN is defined.
interface instr_fetch_stage_if #(
    parameter int PC_W    = 5,
    parameter int INSTR_W = 32
);
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] ifid_instr;
    logic [PC_W-1:0]    ifid_pc_plus4;
    logic               ifid_valid;
    logic               halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]        fetch_count;
    logic [15:0]        stall_count;
`endif

    modport master (
        input  stall, branch_taken, branch_target, instr_in,
`ifdef FETCH_PERF_CNT_EN
        output fetch_count, stall_count,
`endif
        output pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, halted
    );

    modport slave (
        output stall, branch_taken, branch_target, instr_in,
`ifdef FETCH_PERF_CNT_EN
        input  fetch_count, stall_count,
`endif
        input  pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, halted
    );
endinterface

// File: rtl/instr_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush clears everything, kill clears only the
// instruction and valid bit, load captures a new fetch, otherwise hold.
module ifid_reg
    import if_pkg::*;
#(
    parameter int PC_W    = 5,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_flush,
    input  logic               i_kill,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc_plus4,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc_plus4,
    output logic               o_valid
);

    // IF/ID storage with flush > kill > load > hold priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_instr    <= INSTR_W'(NOP_INSTR);
            o_pc_plus4 <= '0;
            o_valid    <= 1'b0;
        end else if (i_flush) begin
            o_instr    <= INSTR_W'(NOP_INSTR);
            o_pc_plus4 <= '0;
            o_valid    <= 1'b0;
        end else if (i_kill) begin
            o_instr    <= INSTR_W'(NOP_INSTR);
            o_valid    <= 1'b0;
        end else if (i_load) begin
            o_instr    <= i_instr;
            o_pc_plus4 <= i_pc_plus4;
            o_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, START/RUN/HALT fetch FSM and IF/ID register.
// Optional fetch/stall performance counters under FETCH_PERF_CNT_EN.
module instr_fetch_stage
    import if_pkg::*;
#(
    parameter int              PC_W    = 5,
    parameter int              INSTR_W = 32,
    parameter logic [PC_W-1:0] HALT_PC = PC_W'(28)
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_stage_if.master  bus
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_target;
    logic            r_halted;
    logic            w_flush;
    logic            w_kill;
    logic            w_load;

    assign w_pc_plus4 = r_pc + PC_W'(PC_STEP);
    assign w_target   = {bus.branch_target[PC_W-1:2], 2'b00};

    // State, PC and halt flag registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= START;
            r_pc     <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= (w_state_nxt == HALT);
        end
    end

    // Next-state, next-PC and IF/ID control decode
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush     = 1'b0;
        w_kill      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            START: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (bus.branch_taken) begin
                    w_pc_nxt = w_target;
                    w_flush  = 1'b1;
                end else if (bus.stall) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_load = 1'b1;
                    if (r_pc == HALT_PC) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end
            HALT: begin
                if (bus.branch_taken) begin
                    w_pc_nxt    = w_target;
                    w_flush     = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_kill = 1'b1;
                end
            end
            default: begin
                w_state_nxt = START;
                w_flush     = 1'b1;
            end
        endcase
    end

    ifid_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_ifid_reg (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (w_flush),
        .i_kill     (w_kill),
        .i_load     (w_load),
        .i_instr    (bus.instr_in),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (bus.ifid_instr),
        .o_pc_plus4 (bus.ifid_pc_plus4),
        .o_valid    (bus.ifid_valid)
    );

    assign bus.pc_out = r_pc;
    assign bus.halted = r_halted;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;
    logic        w_stall_evt;

    assign w_stall_evt = (r_state == RUN) && bus.stall && !bus.branch_taken;

    // Saturating fetch and stall event counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_cnt <= 16'h0000;
            r_stall_cnt <= 16'h0000;
        end else begin
            if (w_load && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'h0001;
            end
            if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'h0001;
            end
        end
    end

    assign bus.fetch_count = r_fetch_cnt;
    assign bus.stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: behavioural model compared every
// cycle plus directed checks of hand-computed values.
module tb_instr_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] mem [8];
    int          checks;
    int          errors;

    instr_fetch_stage_if #(.PC_W(5), .INSTR_W(32)) bus ();

    instr_fetch_stage #(.PC_W(5), .INSTR_W(32), .HALT_PC(5'd28)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.instr_in = mem[bus.pc_out[4:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: phase 0=settle, 1=fetching, 2=stopped
    int          m_phase;
    bit          m_live;
    logic [4:0]  m_pc, m_pp4;
    logic [31:0] m_instr;
    logic        m_valid, m_halted;
    int          m_fc, m_sc;

    always @(posedge clk) begin
        if (!reset) begin
            m_live <= 1'b1; m_phase <= 0; m_pc <= 5'd0; m_pp4 <= 5'd0;
            m_instr <= 32'd0; m_valid <= 1'b0; m_halted <= 1'b0; m_fc <= 0; m_sc <= 0;
        end else if (m_phase == 0) begin
            m_phase <= 1;
        end else if (m_phase == 1) begin
            if (bus.branch_taken) begin
                m_pc <= bus.branch_target & 5'b11100;
                m_instr <= 32'd0; m_pp4 <= 5'd0; m_valid <= 1'b0;
            end else if (bus.stall) begin
                m_sc <= (m_sc == 65535) ? m_sc : m_sc + 1;
            end else begin
                m_instr <= mem[m_pc >> 2];
                m_pp4   <= m_pc + 5'd4;
                m_valid <= 1'b1;
                m_fc    <= (m_fc == 65535) ? m_fc : m_fc + 1;
                if (m_pc == 5'd28) begin
                    m_phase <= 2; m_halted <= 1'b1;
                end else begin
                    m_pc <= m_pc + 5'd4;
                end
            end
        end else begin
            if (bus.branch_taken) begin
                m_pc <= bus.branch_target & 5'b11100;
                m_instr <= 32'd0; m_pp4 <= 5'd0; m_valid <= 1'b0;
                m_halted <= 1'b0; m_phase <= 1;
            end else begin
                m_instr <= 32'd0; m_valid <= 1'b0;
            end
        end
    end

    // Compare DUT against the model on every falling edge once reset was seen
    always @(negedge clk) begin
        if (m_live) begin
            chk("m_pc_out", {27'd0, bus.pc_out}, {27'd0, m_pc});
            chk("m_ifid_instr", bus.ifid_instr, m_instr);
            chk("m_ifid_pc_plus4", {27'd0, bus.ifid_pc_plus4}, {27'd0, m_pp4});
            chk("m_ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, m_valid});
            chk("m_halted", {31'd0, bus.halted}, {31'd0, m_halted});
`ifdef FETCH_PERF_CNT_EN
            chk("m_fetch_count", {16'd0, bus.fetch_count}, m_fc[31:0]);
            chk("m_stall_count", {16'd0, bus.stall_count}, m_sc[31:0]);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, {27'd0, bus.pc_out}, 32'd0);
        chk({tag, "_instr"}, bus.ifid_instr, 32'd0);
        chk({tag, "_pp4"}, {27'd0, bus.ifid_pc_plus4}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.ifid_valid}, 32'd0);
        chk({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_fcnt"}, {16'd0, bus.fetch_count}, 32'd0);
        chk({tag, "_scnt"}, {16'd0, bus.stall_count}, 32'd0);
`endif
    endtask

    initial begin
        checks = 0; errors = 0; m_live = 1'b0;
        mem[0] = 32'h00221820; mem[1] = 32'h00432022; mem[2] = 32'h00642824;
        mem[3] = 32'h00853020; mem[4] = 32'h00A63822; mem[5] = 32'h00C74024;
        mem[6] = 32'h00E84825; mem[7] = 32'h0109502A;
        reset = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 5'd0;
        step(); step();
        chk_reset_vals("rst");
        reset = 1'b1;
        step();
        chk("start_pc", {27'd0, bus.pc_out}, 32'd0);
        chk("start_valid", {31'd0, bus.ifid_valid}, 32'd0);
        step();
        chk("f0_pc", {27'd0, bus.pc_out}, 32'd4);
        chk("f0_instr", bus.ifid_instr, 32'h00221820);
        chk("f0_pp4", {27'd0, bus.ifid_pc_plus4}, 32'd4);
        chk("f0_valid", {31'd0, bus.ifid_valid}, 32'd1);
        step();
        chk("f1_pc", {27'd0, bus.pc_out}, 32'd8);
        chk("f1_instr", bus.ifid_instr, 32'h00432022);
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_pc", {27'd0, bus.pc_out}, 32'd8);
            chk("stall_instr", bus.ifid_instr, 32'h00432022);
        end
        bus.stall = 1'b0;
        step();
        chk("f2_instr", bus.ifid_instr, 32'h00642824);
        chk("f2_pp4", {27'd0, bus.ifid_pc_plus4}, 32'd12);
        chk("f2_pc", {27'd0, bus.pc_out}, 32'd12);
        bus.branch_taken = 1'b1; bus.branch_target = 5'd21;
        step();
        bus.branch_taken = 1'b0;
        chk("br_pc", {27'd0, bus.pc_out}, 32'd20);
        chk("br_valid", {31'd0, bus.ifid_valid}, 32'd0);
        chk("br_instr", bus.ifid_instr, 32'd0);
        step();
        chk("br_fetch", bus.ifid_instr, 32'h00C74024);
        bus.branch_taken = 1'b1; bus.stall = 1'b1; bus.branch_target = 5'd6;
        step();
        bus.branch_taken = 1'b0; bus.stall = 1'b0;
        chk("brst_pc", {27'd0, bus.pc_out}, 32'd4);
        chk("brst_valid", {31'd0, bus.ifid_valid}, 32'd0);
        for (int i = 0; i < 20 && bus.pc_out != 5'd28; i++) step();
        chk("reach_28", {27'd0, bus.pc_out}, 32'd28);
        step();
        chk("last_instr", bus.ifid_instr, 32'h0109502A);
        chk("last_halted", {31'd0, bus.halted}, 32'd1);
        step();
        chk("halt_valid", {31'd0, bus.ifid_valid}, 32'd0);
        chk("halt_instr", bus.ifid_instr, 32'd0);
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_pc", {27'd0, bus.pc_out}, 32'd28);
            chk("halt_flag", {31'd0, bus.halted}, 32'd1);
        end
        bus.stall = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 5'd0;
        step();
        bus.branch_taken = 1'b0;
        chk("resume_pc", {27'd0, bus.pc_out}, 32'd0);
        chk("resume_halted", {31'd0, bus.halted}, 32'd0);
        step(); step();
        bus.stall = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_reset_vals("rst_stall");
        reset = 1'b1; bus.stall = 1'b0;
        for (int i = 0; i < 40 && !bus.halted; i++) step();
        chk("halt_again", {31'd0, bus.halted}, 32'd1);
        reset = 1'b0;
        step();
        chk_reset_vals("rst_halt");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
